reg_file_ctx: RTL and testbench
===============================

# reg_file_ctx

Parametrised general-purpose register file for the accumulator-style datapath. It adds three things to the basic register file:
- two independent read ports plus a dedicated register-0 (accumulator) output;
- reset of all registers to zero;
- a context save/restore sequencer that streams every register out to, or in from, memory over valid/ready handshakes.

It sits between the decode/ALU stage and the data-memory port used for interrupt and task context switches.

## Interface
Parameters:
- W, 8, register width in bits
- D, 3, address width; the file holds 2**D registers

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- reg_write  input  1  write enable for core write port
- zero_store  input  1  when 1, a core write targets register 0 regardless of write_addr
- write_addr  input  D  core write address
- data_in  input  W  core write data
- rd_addr_a, rd_addr_b  input  D each  read addresses
- rd_data_a, rd_data_b  output  W each  combinational read data
- zero_reg_out  output  W  always equals register 0
- ctx_save, ctx_restore  input  1 each  start pulses, sampled only in IDLE
- busy  output  1  sequencer active; core must stall
- ctx_done  output  1  one-cycle pulse when a save or restore completes
- spill_valid  output  1  spill_data is valid
- spill_ready  input  1  memory accepts spill_data
- spill_data  output  W  register being saved
- ctx_idx  output  D  index of the register currently being transferred
- fill_valid  input  1  fill_data is valid
- fill_ready  output  1  file accepts fill_data
- fill_data  input  W  register value being restored

## Operation
- Core write: when reg_write=1 and busy=0, the target register ← data_in. The target is register 0 if zero_store=1, otherwise write_addr. When busy=1, core writes are dropped.
- Reads are combinational from register state. Without bypass, a write is visible on the cycle after the edge.
- State machine: IDLE, SAVE, RESTORE; counter idx (D bits) drives ctx_idx.
- IDLE:
  - ctx_save=1 → SAVE, idx←0.
  - Else ctx_restore=1 → RESTORE, idx←0.
  - Both high at once: SAVE wins.
- SAVE:
  - spill_valid=1; spill_data=registers[idx].
  - On spill_valid&spill_ready: if idx=2**D−1 → IDLE and ctx_done=1 next cycle; else idx←idx+1.
- RESTORE:
  - fill_ready=1.
  - On fill_valid&fill_ready: registers[idx]←fill_data. If idx=2**D−1 → IDLE and ctx_done=1 next cycle; else idx←idx+1.
- ctx_save and ctx_restore are ignored while busy.
- spill_valid, once high, stays high with spill_data stable until accepted. Registers cannot change in SAVE, because core writes are blocked.
- busy=1 exactly when state≠IDLE.
- Reset (at any time, including mid-transfer):
  - state←IDLE, idx←0, all registers←0, ctx_done←0.
  - busy, spill_valid and fill_ready are low in the following cycle.
  - No partial-restore data is preserved beyond the registers already written before reset, and those are also cleared.

## Timing
- Reset values: rd_data_a=rd_data_b=zero_reg_out=0, busy=0, ctx_done=0, spill_valid=0, fill_ready=0, spill_data=0, ctx_idx=0.
- Start latency: ctx_save seen at edge N → busy=1 and spill_valid=1 from cycle N+1.
- Throughput: one register per cycle with continuous ready/valid. A full save or restore takes 2**D handshake cycles; ctx_done pulses on the cycle after the last handshake, the same cycle busy falls.
- Back-pressure: no bound; the sequencer waits indefinitely.
- A new ctx_save may be accepted in the ctx_done cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read port whose address equals the active core write target (reg_write=1, busy=0) returns data_in in the same cycle;
  - zero_reg_out bypasses likewise for register-0 writes;
  - during RESTORE, reads of registers[idx] return fill_data on the handshake cycle.
- Undefined: reads always return stored state, with one-cycle write-to-read visibility.

## Structure
- Package regfile_pkg: state enum typedef (IDLE, SAVE, RESTORE) and default W/D localparams.
- Sub-module ctx_sequencer holds the FSM, idx counter and handshake/done logic. It outputs a write strobe, index and busy to the storage array in reg_file_ctx.

## Test plan
- Reset then read all addresses → every read port and zero_reg_out = 0.
- Write 0x5A to reg 3, then zero_store with 0x11 and write_addr=3 → reg 3=0x5A, reg 0=0x11; rd_data_a=0x5A one cycle after the write (same cycle with REGFILE_BYPASS_EN).
- Load regs with 0x10..0x17, ctx_save with spill_ready=1 → spill_data 0x10..0x17 on 8 consecutive cycles, ctx_idx 0..7; ctx_done on cycle 9 after the pulse.
- Save with spill_ready toggling 1,0,0,1… → each value held stable while not ready; no value skipped or repeated; a reg_write 0xFF to reg 2 during busy is dropped.
- ctx_restore with fill_data 0xA0..0xA7 → regs 0..7 = 0xA0..0xA7 after ctx_done; ctx_save and ctx_restore pulsed together → SAVE performed.
- Assert reset after the 4th restore handshake → next cycle busy=0, fill_ready=0, all regs 0, ctx_idx=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the context-switching register file.
package regfile_pkg;
  localparam int W_DEF = 8;
  localparam int D_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_e;
endpackage

// File: rtl/ctx_sequencer.sv
// Context save/restore sequencer: walks idx across every register, one
// valid/ready handshake per register, and pulses ctx_done after the last one.
module ctx_sequencer
  import regfile_pkg::*;
#(
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ctx_save,
  input  logic         ctx_restore,
  input  logic         spill_ready,
  input  logic         fill_valid,
  output logic         busy,
  output logic         ctx_done,
  output logic         spill_valid,
  output logic         fill_ready,
  output logic         fill_we,
  output logic [D-1:0] idx
);
  ctx_state_e   state_q;
  logic [D-1:0] idx_q;
  logic         done_q;
  logic         last;

  assign last = &idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Save has priority when both start pulses arrive together.
          if (ctx_save) begin
            state_q <= SAVE;
            idx_q   <= '0;
          end else if (ctx_restore) begin
            state_q <= RESTORE;
            idx_q   <= '0;
          end
        end
        SAVE: begin
          if (spill_ready) begin
            idx_q <= idx_q + 1'b1;
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        RESTORE: begin
          if (fill_valid) begin
            idx_q <= idx_q + 1'b1;
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign spill_valid = (state_q == SAVE);
  assign fill_ready  = (state_q == RESTORE);
  assign fill_we     = fill_ready & fill_valid;
  assign ctx_done    = done_q;
  assign idx         = idx_q;
endmodule

// File: rtl/reg_file_ctx.sv
// Register file with two read ports, accumulator output and context
// save/restore streaming. Optional same-cycle read bypass: REGFILE_BYPASS_EN.
module reg_file_ctx
  import regfile_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = D_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reg_write,
  input  logic         zero_store,
  input  logic [D-1:0] write_addr,
  input  logic [W-1:0] data_in,
  input  logic [D-1:0] rd_addr_a,
  input  logic [D-1:0] rd_addr_b,
  output logic [W-1:0] rd_data_a,
  output logic [W-1:0] rd_data_b,
  output logic [W-1:0] zero_reg_out,
  input  logic         ctx_save,
  input  logic         ctx_restore,
  output logic         busy,
  output logic         ctx_done,
  output logic         spill_valid,
  input  logic         spill_ready,
  output logic [W-1:0] spill_data,
  output logic [D-1:0] ctx_idx,
  input  logic         fill_valid,
  output logic         fill_ready,
  input  logic [W-1:0] fill_data
);
  localparam int N = 2**D;

  logic [N-1:0][W-1:0] regs_q;
  logic                fill_we;
  logic                core_we;
  logic [D-1:0]        core_addr;
  logic [D-1:0]        idx;

  ctx_sequencer #(.D(D)) u_seq (
    .clk         (clk),
    .reset       (reset),
    .ctx_save    (ctx_save),
    .ctx_restore (ctx_restore),
    .spill_ready (spill_ready),
    .fill_valid  (fill_valid),
    .busy        (busy),
    .ctx_done    (ctx_done),
    .spill_valid (spill_valid),
    .fill_ready  (fill_ready),
    .fill_we     (fill_we),
    .idx         (idx)
  );

  // Core writes are dropped while the sequencer owns the file.
  assign core_we   = reg_write & ~busy;
  assign core_addr = zero_store ? '0 : write_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else if (core_we) begin
      regs_q[core_addr] <= data_in;
    end else if (fill_we) begin
      regs_q[idx] <= fill_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data_a    = regs_q[rd_addr_a];
    rd_data_b    = regs_q[rd_addr_b];
    zero_reg_out = regs_q[0];
    if (core_we) begin
      if (rd_addr_a == core_addr) rd_data_a = data_in;
      if (rd_addr_b == core_addr) rd_data_b = data_in;
      if (core_addr == '0)        zero_reg_out = data_in;
    end else if (fill_we) begin
      if (rd_addr_a == idx) rd_data_a = fill_data;
      if (rd_addr_b == idx) rd_data_b = fill_data;
      if (idx == '0)        zero_reg_out = fill_data;
    end
  end
`else
  assign rd_data_a    = regs_q[rd_addr_a];
  assign rd_data_b    = regs_q[rd_addr_b];
  assign zero_reg_out = regs_q[0];
`endif

  assign spill_data = regs_q[idx];
  assign ctx_idx    = idx;
endmodule

// File: tb/tb_reg_file_ctx.sv
// Randomized scoreboard bench for reg_file_ctx against an array-based model.
module tb_reg_file_ctx;
  localparam int W = 8;
  localparam int D = 3;
  localparam int N = 8;

  typedef struct {
    int idx;
    int data;
  } spill_t;

  logic         clk = 1'b0;
  logic         reset, reg_write, zero_store;
  logic [D-1:0] write_addr, rd_addr_a, rd_addr_b;
  logic [W-1:0] data_in, fill_data;
  logic [W-1:0] rd_data_a, rd_data_b, zero_reg_out, spill_data;
  logic         ctx_save, ctx_restore, busy, ctx_done;
  logic         spill_valid, spill_ready, fill_valid, fill_ready;
  logic [D-1:0] ctx_idx;

  int     checks = 0;
  int     errors = 0;
  int     model [N];
  spill_t sb [$];

  reg_file_ctx #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .zero_store(zero_store),
    .write_addr(write_addr), .data_in(data_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .zero_reg_out(zero_reg_out),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore), .busy(busy), .ctx_done(ctx_done),
    .spill_valid(spill_valid), .spill_ready(spill_ready), .spill_data(spill_data),
    .ctx_idx(ctx_idx), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_data(fill_data)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected spill beats and checks hold-stability under back-pressure.
  bit hold_pend = 1'b0;
  int hold_data, hold_idx;
  always @(negedge clk) begin
    if (hold_pend && spill_valid) begin
      chk("spill_hold_data", int'(spill_data), hold_data);
      chk("spill_hold_idx", int'(ctx_idx), hold_idx);
    end
    hold_pend = spill_valid && !spill_ready && !reset;
    hold_data = int'(spill_data);
    hold_idx  = int'(ctx_idx);
    if (spill_valid && spill_ready && !reset) begin
      if (sb.size() == 0) begin
        chk("spill_unexpected", 1, 0);
      end else begin
        spill_t e;
        e = sb.pop_front();
        chk("spill_idx", int'(ctx_idx), e.idx);
        chk("spill_data", int'(spill_data), e.data);
      end
    end
  end

  task automatic check_reads();
    for (int a = 0; a < N; a++) begin
      rd_addr_a = a[D-1:0];
      rd_addr_b = 3'(N - 1 - a);
      #1;
      chk("rd_data_a", int'(rd_data_a), model[a]);
      chk("rd_data_b", int'(rd_data_b), model[N-1-a]);
    end
    chk("zero_reg_out", int'(zero_reg_out), model[0]);
  endtask

  task automatic wr(input int addr, input int data, input bit zs);
    reg_write  = 1'b1;
    zero_store = zs;
    write_addr = addr[D-1:0];
    data_in    = data[W-1:0];
    tick();
    reg_write  = 1'b0;
    zero_store = 1'b0;
    model[zs ? 0 : addr] = data & 8'hFF;
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random ready
  task automatic run_save(input int mode, input bit with_restore, input bit drop_wr);
    int hs, cyc;
    bit rdy;
    for (int i = 0; i < N; i++) sb.push_back('{idx: i, data: model[i]});
    ctx_save    = 1'b1;
    ctx_restore = with_restore;
    tick();
    ctx_save    = 1'b0;
    ctx_restore = 1'b0;
    chk("save_busy", int'(busy), 1);
    chk("save_spill_valid", int'(spill_valid), 1);
    chk("save_fill_ready", int'(fill_ready), 0);
    hs = 0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      spill_ready = rdy;
      if (drop_wr && cyc == 2) begin
        reg_write  = 1'b1;
        write_addr = 3'd2;
        data_in    = 8'hFF;
      end
      tick();
      reg_write = 1'b0;
      if (rdy) hs++;
      if (hs == N) break;
      chk("save_done_early", int'(ctx_done), 0);
    end
    spill_ready = 1'b0;
    chk("save_done", int'(ctx_done), 1);
    chk("save_busy_fall", int'(busy), 0);
    if (mode == 0) chk("save_cycles", cyc, N);
    #2;
    chk("save_sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_restore(input bit rnd);
    int midx;
    ctx_restore = 1'b1;
    tick();
    ctx_restore = 1'b0;
    midx = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      fill_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      fill_data  = rnd ? 8'($urandom) : 8'(8'hA0 + midx);
      chk("restore_fill_ready", int'(fill_ready), 1);
      chk("restore_idx", int'(ctx_idx), midx);
      tick();
      if (fill_valid) begin
        model[midx] = int'(fill_data);
        if (midx == N - 1) break;
        midx++;
      end
      chk("restore_done_early", int'(ctx_done), 0);
    end
    fill_valid = 1'b0;
    chk("restore_done", int'(ctx_done), 1);
    chk("restore_busy_fall", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; reg_write = 1'b0; zero_store = 1'b0; write_addr = '0;
    data_in = '0; rd_addr_a = '0; rd_addr_b = '0; ctx_save = 1'b0;
    ctx_restore = 1'b0; spill_ready = 1'b0; fill_valid = 1'b0; fill_data = '0;
    for (int i = 0; i < N; i++) model[i] = 0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(ctx_done), 0);
    chk("rst_spill_valid", int'(spill_valid), 0);
    chk("rst_fill_ready", int'(fill_ready), 0);
    chk("rst_spill_data", int'(spill_data), 0);
    chk("rst_ctx_idx", int'(ctx_idx), 0);
    check_reads();

    // Core write and zero_store
    tick();
    wr(3, 8'h5A, 1'b0);
    wr(3, 8'h11, 1'b1);
    check_reads();

    // Full save with continuous ready
    tick();
    for (int i = 0; i < N; i++) wr(i, 8'h10 + i, 1'b0);
    run_save(0, 1'b0, 1'b0);
    check_reads();

    // Back-pressured save; a core write during busy must be dropped
    run_save(1, 1'b0, 1'b1);
    check_reads();

    // Restore A0..A7, then simultaneous start pulses pick save
    run_restore(1'b0);
    check_reads();
    run_save(0, 1'b1, 1'b0);

    // Randomized traffic
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++)
        wr($urandom_range(0, N - 1), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      check_reads();
      run_save(2, 1'b0, 1'($urandom_range(0, 1)));
      run_restore(1'b1);
      check_reads();
    end

    // Reset after the fourth restore handshake
    ctx_restore = 1'b1;
    tick();
    ctx_restore = 1'b0;
    fill_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill_data = 8'(8'hC0 + i);
      tick();
    end
    fill_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fill_ready", int'(fill_ready), 0);
    chk("mid_rst_ctx_idx", int'(ctx_idx), 0);
    chk("mid_rst_done", int'(ctx_done), 0);
    check_reads();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
